vec_pipe_scoreboard: RTL

//  Parametrised carrier pipeline for LANES-wide vector ops between decode and write-back.
//  - Each stage has a valid/ready handshake with bubble collapsing.
//  - Supports a global flush.
//  - A per-register scoreboard blocks issue of ops whose sources are still being written (RAW).
//  - Replaces the fixed, stall-less pipe registers of the current core.

---
 rtl/vec_pipe_scoreboard.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vec_pipe_scoreboard.sv
// Vector-op carrier pipe with per-register RAW scoreboard; DEPTH cycles issue-to-retire, 1 op/cycle.
// Backpressure: out_ready stalls fill bubbles upstream; in_ready drops on a full pipe, a source hazard or flush.
module vec_pipe_scoreboard #(
  parameter int REG_W    = 8,
  parameter int LANES    = 4,
  parameter int SEL_BITS = 4,
  parameter int DEPTH    = 3,
  parameter int CTRL_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_BITS-1:0]       in_rs1,
  input  logic                      in_rs1_used,
  input  logic [SEL_BITS-1:0]       in_rs2,
  input  logic                      in_rs2_used,
  input  logic [SEL_BITS-1:0]       in_rd,
  input  logic                      in_rd_we,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [LANES*REG_W-1:0]    in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_BITS-1:0]       out_rd,
  output logic                      out_rd_we,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [LANES*REG_W-1:0]    out_data,
  output logic                      raw_stall,
  output logic                      busy
);

  localparam int DATA_W = LANES * REG_W;
  localparam int NREG   = 1 << SEL_BITS;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [SEL_BITS-1:0] rd;
    logic                rdWe;
    logic [CTRL_W-1:0]   ctrl;
    logic [DATA_W-1:0]   data;
  } opT;

  opT               stage [DEPTH];
  logic [DEPTH-1:0] stageVld;
  logic [DEPTH-1:0] adv;
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  incVec;
  logic [NREG-1:0]  decVec;
  logic             hit;
  logic             accept;
  logic             retire;
  opT               issueOp;

  // adv[i]: stage i may hand its contents downstream this cycle.
  always_comb begin
    logic room;
    room           = out_ready || !stageVld[DEPTH-1];
    adv            = '0;
    adv[DEPTH-1]   = room;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      room   = room || !stageVld[i+1];
      adv[i] = room;
    end
  end

  // No bypass: a source whose writer retires this cycle still counts as pending.
  assign hit       = (in_rs1_used && cnt[in_rs1] != '0) || (in_rs2_used && cnt[in_rs2] != '0);
  assign in_ready  = adv[0] && !hit && !flush;
  assign accept    = in_valid && in_ready;
  assign raw_stall = in_valid && hit && !flush;
  assign retire    = stageVld[DEPTH-1] && out_ready;

  assign issueOp = '{rd: in_rd, rdWe: in_rd_we, ctrl: in_ctrl, data: in_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stageVld <= '0;
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      stageVld <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        if (adv[i-1]) begin
          stage[i]    <= stage[i-1];
          stageVld[i] <= stageVld[i-1];
        end
      end
      if (adv[0]) begin
        stageVld[0] <= accept;
        if (accept) stage[0] <= issueOp;
      end
    end
  end

  assign incVec = (accept && in_rd_we) ? (NREG'(1) << in_rd) : '0;
  assign decVec = (retire && stage[DEPTH-1].rdWe) ? (NREG'(1) << stage[DEPTH-1].rd) : '0;

  // A retire during flush is delivered, but the clear wins over its decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (incVec[r] && !decVec[r]) cnt[r] <= cnt[r] + CNT_W'(1);
        else if (decVec[r] && !incVec[r]) cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  assign out_valid = stageVld[DEPTH-1];
  assign out_rd    = stage[DEPTH-1].rd;
  assign out_rd_we = stage[DEPTH-1].rdWe;
  assign out_ctrl  = stage[DEPTH-1].ctrl;
  assign out_data  = stage[DEPTH-1].data;
  assign busy      = |stageVld;

endmodule
